hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage core; sequences PC, IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/hazard_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller.
// The slave modport is the controller side; the master modport is the pipeline side.
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic             IDEX_MemRead;
   logic [4:0]       IDEX_Rt;
   logic [4:0]       IFID_Rs;
   logic [4:0]       IFID_Rt;
   logic             IFID_UsesRt;
   logic             IFID_MulDiv;
   logic             IFID_ReadHiLo;
   logic             EX_MulDivStart;
   logic             EX_BranchTaken;
   logic             DMem_Ready;
   logic             PC_Write;
   logic             IFID_Write;
   logic             IFID_Flush;
   logic             IDEX_Bubble;
   logic             EXMEM_Write;
   logic             MEMWB_Write;
   logic             MD_Busy;
   logic [CNT_W-1:0] Stall_Count;

   modport master (
      output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_MulDiv,
             IFID_ReadHiLo, EX_MulDivStart, EX_BranchTaken, DMem_Ready,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write,
             MEMWB_Write, MD_Busy, Stall_Count
   );

   modport slave (
      input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_MulDiv,
             IFID_ReadHiLo, EX_MulDivStart, EX_BranchTaken, DMem_Ready,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write,
             MEMWB_Write, MD_Busy, Stall_Count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze controller for the 5-stage core: load-use, mult/div HI/LO busy window,
// taken-branch flush and data-memory freeze, plus a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic     clk,
   input  logic     reset,
   hazard_if.slave  hz
);
   localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

   typedef enum logic [1:0] {
      M_RUN,
      M_STALL,
      M_FLUSH,
      M_FREEZE
   } mode_e;

   logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             md_busy;
   logic             load_use;
   logic             md_haz;
   mode_e            mode;

   assign md_busy = (md_cnt_q != '0);

   assign load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                     ((hz.IDEX_Rt == hz.IFID_Rs) ||
                      (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

   assign md_haz = (md_busy || hz.EX_MulDivStart) && (hz.IFID_ReadHiLo || hz.IFID_MulDiv);

   // Reset forces RUN so the pipeline drains cleanly while the controller state clears.
   always_comb begin
      mode = M_RUN;
      if (reset)                     mode = M_RUN;
      else if (!hz.DMem_Ready)       mode = M_FREEZE;
      else if (hz.EX_BranchTaken)    mode = M_FLUSH;
      else if (load_use || md_haz)   mode = M_STALL;
   end

   always_comb begin
      hz.PC_Write    = 1'b1;
      hz.IFID_Write  = 1'b1;
      hz.IFID_Flush  = 1'b0;
      hz.IDEX_Bubble = 1'b0;
      hz.EXMEM_Write = 1'b1;
      hz.MEMWB_Write = 1'b1;
      unique case (mode)
         M_FREEZE: begin
            hz.PC_Write    = 1'b0;
            hz.IFID_Write  = 1'b0;
            hz.EXMEM_Write = 1'b0;
            hz.MEMWB_Write = 1'b0;
         end
         M_FLUSH: begin
            hz.IFID_Flush  = 1'b1;
            hz.IDEX_Bubble = 1'b1;
         end
         M_STALL: begin
            hz.PC_Write    = 1'b0;
            hz.IFID_Write  = 1'b0;
            hz.IDEX_Bubble = 1'b1;
         end
         default: ;
      endcase
   end

   // The mult/div unit keeps counting through a freeze; a start is only accepted when idle and unfrozen.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (hz.EX_MulDivStart && !md_busy && hz.DMem_Ready)
         md_cnt_d = MD_W'(MD_LAT - 1);
      else if (md_busy)
         md_cnt_d = md_cnt_q - MD_W'(1);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!hz.PC_Write && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.MD_Busy     = md_busy;
   assign hz.Stall_Count = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   hazard_if #(.CNT_W(16)) hz ();
   hazard_if #(.CNT_W(4))  sb ();

   hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) u_dut (.clk(clk), .reset(reset), .hz(hz));
   hazard_ctrl #(.MD_LAT(4), .CNT_W(4))  u_sat (.clk(clk), .reset(reset), .hz(sb));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      hz.IDEX_MemRead   = 1'b0;
      hz.IDEX_Rt        = 5'd0;
      hz.IFID_Rs        = 5'd0;
      hz.IFID_Rt        = 5'd0;
      hz.IFID_UsesRt    = 1'b0;
      hz.IFID_MulDiv    = 1'b0;
      hz.IFID_ReadHiLo  = 1'b0;
      hz.EX_MulDivStart = 1'b0;
      hz.EX_BranchTaken = 1'b0;
      hz.DMem_Ready     = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Enable vector {PC, IFID_W, Flush, Bubble, EXMEM, MEMWB}
   function automatic logic [5:0] en();
      return {hz.PC_Write, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Bubble,
              hz.EXMEM_Write, hz.MEMWB_Write};
   endfunction

   initial begin
      sb.IDEX_MemRead   = 1'b0;
      sb.IDEX_Rt        = 5'd0;
      sb.IFID_Rs        = 5'd0;
      sb.IFID_Rt        = 5'd0;
      sb.IFID_UsesRt    = 1'b0;
      sb.IFID_MulDiv    = 1'b0;
      sb.IFID_ReadHiLo  = 1'b0;
      sb.EX_MulDivStart = 1'b0;
      sb.EX_BranchTaken = 1'b0;
      sb.DMem_Ready     = 1'b1;

      // Reset overrides freeze/flush/load-use
      reset = 1'b1;
      idle();
      hz.DMem_Ready     = 1'b0;
      hz.EX_BranchTaken = 1'b1;
      hz.IDEX_MemRead   = 1'b1;
      hz.IDEX_Rt        = 5'd5;
      hz.IFID_Rs        = 5'd5;
      #3;
      chk("reset_enables", 32'(en()), 32'b110011);
      tick();
      tick();
      reset = 1'b0;
      idle();
      #3;
      chk("reset_stall_cnt", 32'(hz.Stall_Count), 0);
      chk("reset_md_busy", 32'(hz.MD_Busy), 0);
      chk("run_enables", 32'(en()), 32'b110011);

      // T1 load-use
      tick();
      hz.IDEX_MemRead = 1'b1;
      hz.IDEX_Rt      = 5'd5;
      hz.IFID_Rs      = 5'd5;
      #3;
      chk("t1_stall_enables", 32'(en()), 32'b000111);
      tick();
      idle();
      #3;
      chk("t1_stall_cnt", 32'(hz.Stall_Count), 1);
      chk("t1_release", 32'(en()), 32'b110011);

      // T2 $zero and unused Rt (combinational, same cycle)
      hz.IDEX_MemRead = 1'b1;
      hz.IDEX_Rt      = 5'd0;
      hz.IFID_Rs      = 5'd0;
      #1;
      chk("t2_zero_reg", 32'(hz.PC_Write), 1);
      hz.IDEX_Rt     = 5'd7;
      hz.IFID_Rt     = 5'd7;
      hz.IFID_Rs     = 5'd3;
      hz.IFID_UsesRt = 1'b0;
      #1;
      chk("t2_rt_unused", 32'(hz.PC_Write), 1);
      hz.IFID_UsesRt = 1'b1;
      #1;
      chk("t2_rt_used", 32'(en()), 32'b000111);
      idle();

      // T3 mult/div busy window
      tick();
      hz.EX_MulDivStart = 1'b1;
      hz.IFID_ReadHiLo  = 1'b1;
      #3;
      chk("t3_c0_stall", 32'(hz.PC_Write), 0);
      chk("t3_c0_busy", 32'(hz.MD_Busy), 0);
      for (int c = 1; c <= 3; c++) begin
         tick();
         hz.EX_MulDivStart = 1'b0;
         #3;
         chk($sformatf("t3_c%0d_busy", c), 32'(hz.MD_Busy), 1);
         chk($sformatf("t3_c%0d_stall", c), 32'(en()), 32'b000111);
      end
      tick();
      #3;
      chk("t3_c4_busy", 32'(hz.MD_Busy), 0);
      chk("t3_c4_run", 32'(en()), 32'b110011);
      chk("t3_stall_cnt", 32'(hz.Stall_Count), 5);
      idle();

      // T4 flush overrides load-use and md_haz; also launches a busy window
      tick();
      hz.IDEX_MemRead   = 1'b1;
      hz.IDEX_Rt        = 5'd5;
      hz.IFID_Rs        = 5'd5;
      hz.EX_MulDivStart = 1'b1;
      hz.IFID_MulDiv    = 1'b1;
      hz.EX_BranchTaken = 1'b1;
      #3;
      chk("t4_flush", 32'(en()), 32'b111111);

      // T5 freeze for 3 cycles with a taken branch during the busy window
      tick();
      idle();
      hz.DMem_Ready     = 1'b0;
      hz.EX_BranchTaken = 1'b1;
      #3;
      chk("t4_no_count", 32'(hz.Stall_Count), 5);
      chk("t5_busy", 32'(hz.MD_Busy), 1);
      chk("t5_f0_enables", 32'(en()), 32'b000000);
      tick();
      #3;
      chk("t5_f1_enables", 32'(en()), 32'b000000);
      tick();
      #3;
      chk("t5_f2_busy", 32'(hz.MD_Busy), 1);
      tick();
      hz.DMem_Ready = 1'b1;
      #3;
      chk("t5_md_decremented", 32'(hz.MD_Busy), 0);
      chk("t5_stall_cnt", 32'(hz.Stall_Count), 8);
      chk("t5_branch_reasserts", 32'(en()), 32'b111111);
      idle();

      // T6 reset during busy window
      tick();
      hz.EX_MulDivStart = 1'b1;
      tick();
      hz.EX_MulDivStart = 1'b0;
      #3;
      chk("t6_busy_before", 32'(hz.MD_Busy), 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #3;
      chk("t6_busy_cleared", 32'(hz.MD_Busy), 0);
      chk("t6_cnt_cleared", 32'(hz.Stall_Count), 0);

      // Saturation on the CNT_W=4 instance: 20 freeze cycles
      chk("sat_start", 32'(sb.Stall_Count), 0);
      sb.DMem_Ready = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      #3;
      chk("sat_14", 32'(sb.Stall_Count), 14);
      for (int i = 0; i < 6; i++) tick();
      sb.DMem_Ready = 1'b1;
      #3;
      chk("sat_20", 32'(sb.Stall_Count), 15);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
